// File: rtl/lcd_bus_decoder.sv
// Shadow decoder for an HD44780-style LCD write bus: mirrors DDRAM into a 2x16 frame buffer.
// Optional macro LCD_MON_READ_EN adds bus read-back (o_lcd_dq / o_lcd_dq_oe).
module lcd_bus_decoder #(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_rw,
  input  logic       i_lcd_e,
  input  logic [7:0] i_lcd_data,
  input  logic [4:0] i_rd_addr,
  output logic [7:0] o_rd_char,
  output logic [6:0] o_ac,
  output logic       o_busy,
  output logic       o_disp_on,
  output logic       o_wr_strobe,
  output logic [4:0] o_wr_pos,
  output logic [7:0] o_wr_char,
  output logic       o_clear_pulse,
  output logic       o_err_busy
`ifdef LCD_MON_READ_EN
  ,
  output logic [7:0] o_lcd_dq,
  output logic       o_lcd_dq_oe
`endif
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic          r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic          r_e_s1, r_e_s2, r_e_d;
  logic [7:0]    r_data_s1, r_data_s2;

  logic [7:0]    r_shadow [32];
  logic [7:0]    r_rd_char;
  logic [6:0]    r_ac;
  logic          r_id;
  logic          r_cgram;
  logic          r_disp_on;
  logic [CW-1:0] r_busy_cnt;
  logic          r_pend_clr;
  logic [4:0]    r_clr_idx;
  logic          r_wr_strobe;
  logic [4:0]    r_wr_pos;
  logic [7:0]    r_wr_char;
  logic          r_clear_pulse;
  logic          r_err_busy;

  logic          w_e_fall, w_cap, w_exec;
  logic          w_vis;
  logic [4:0]    w_pos;
  logic [6:0]    w_ac_nx;
  logic          w_id_nx, w_cgram_nx, w_disp_nx;
  logic [CW-1:0] w_busy_ld;
  logic          w_store, w_clr_req;
  logic          w_rd_step;

  function automatic logic [6:0] f_ac_inc(input logic [6:0] a);
    if (a == 7'h27)      return 7'h40;
    else if (a == 7'h67) return 7'h00;
    else                 return a + 7'd1;
  endfunction

  function automatic logic [6:0] f_ac_dec(input logic [6:0] a);
    if (a == 7'h00)      return 7'h67;
    else if (a == 7'h40) return 7'h27;
    else                 return a - 7'd1;
  endfunction

  function automatic logic [6:0] f_ac_step(input logic [6:0] a, input logic inc);
    return inc ? f_ac_inc(a) : f_ac_dec(a);
  endfunction

  // Addresses in the gaps between the two DDRAM lines are not real cells.
  function automatic logic [6:0] f_ac_fix(input logic [6:0] a);
    if ((a >= 7'h28 && a <= 7'h3F) || a >= 7'h68) return 7'h00;
    else                                          return a;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_s1   <= 1'b0;
      r_rs_s2   <= 1'b0;
      r_rw_s1   <= 1'b0;
      r_rw_s2   <= 1'b0;
      r_e_s1    <= 1'b0;
      r_e_s2    <= 1'b0;
      r_e_d     <= 1'b0;
      r_data_s1 <= 8'h00;
      r_data_s2 <= 8'h00;
    end else begin
      r_rs_s1   <= i_lcd_rs;
      r_rs_s2   <= r_rs_s1;
      r_rw_s1   <= i_lcd_rw;
      r_rw_s2   <= r_rw_s1;
      r_e_s1    <= i_lcd_e;
      r_e_s2    <= r_e_s1;
      r_e_d     <= r_e_s2;
      r_data_s1 <= i_lcd_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_e_fall = r_e_d & ~r_e_s2;
  assign w_cap    = w_e_fall & ~r_rw_s2;
  assign w_exec   = w_cap & (r_state != ST_CLEAR);
  assign w_vis    = (r_ac[6:4] == 3'b000) | (r_ac[6:4] == 3'b100);
  assign w_pos    = {r_ac[6], r_ac[3:0]};

`ifdef LCD_MON_READ_EN
  assign w_rd_step   = w_e_fall & r_rw_s2 & r_rs_s2 & (r_state != ST_CLEAR);
  assign o_lcd_dq_oe = r_e_s2 & r_rw_s2;
  assign o_lcd_dq    = r_rs_s2 ? (w_vis ? r_shadow[w_pos] : 8'h00) : {o_busy, r_ac};
`else
  assign w_rd_step = 1'b0;
`endif

  // Decode of the captured write; applied only when w_exec is set.
  always_comb begin
    w_ac_nx    = r_ac;
    w_id_nx    = r_id;
    w_cgram_nx = r_cgram;
    w_disp_nx  = r_disp_on;
    w_busy_ld  = CW'(BUSY_SHORT);
    w_store    = 1'b0;
    w_clr_req  = 1'b0;
    if (!r_rs_s2) begin
      casez (r_data_s2)
        8'b1???????: begin
          w_cgram_nx = 1'b0;
          w_ac_nx    = f_ac_fix(r_data_s2[6:0]);
        end
        8'b01??????: w_cgram_nx = 1'b1;
        8'b001?????: ;
        8'b0001????: begin
          if (!r_data_s2[3]) w_ac_nx = f_ac_step(r_ac, r_data_s2[2]);
        end
        8'b00001???: w_disp_nx = r_data_s2[2];
        8'b000001??: w_id_nx   = r_data_s2[1];
        8'b0000001?: begin
          w_ac_nx   = 7'h00;
          w_busy_ld = CW'(BUSY_LONG);
        end
        8'b00000001: begin
          w_ac_nx   = 7'h00;
          w_id_nx   = 1'b1;
          w_busy_ld = CW'(BUSY_LONG);
          w_clr_req = 1'b1;
        end
        default: ;
      endcase
    end else if (!r_cgram) begin
      w_store = w_vis;
      w_ac_nx = f_ac_step(r_ac, r_id);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (w_exec) w_state_nx = ST_EXEC;
      ST_EXEC: begin
        if (r_pend_clr)  w_state_nx = ST_CLEAR;
        else if (w_exec) w_state_nx = ST_EXEC;
        else             w_state_nx = ST_IDLE;
      end
      ST_CLEAR: if (r_clr_idx == 5'd31) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac          <= 7'h00;
      r_id          <= 1'b1;
      r_cgram       <= 1'b0;
      r_disp_on     <= 1'b0;
      r_busy_cnt    <= '0;
      r_pend_clr    <= 1'b0;
      r_clr_idx     <= 5'd0;
      r_wr_strobe   <= 1'b0;
      r_wr_pos      <= 5'd0;
      r_wr_char     <= 8'h00;
      r_clear_pulse <= 1'b0;
      r_err_busy    <= 1'b0;
    end else begin
      r_wr_strobe   <= 1'b0;
      r_clear_pulse <= (r_state == ST_CLEAR) && (r_clr_idx == 5'd31);
      if (w_cap && (o_busy || r_state == ST_CLEAR)) r_err_busy <= 1'b1;
      if (w_exec) begin
        r_ac       <= w_ac_nx;
        r_id       <= w_id_nx;
        r_cgram    <= w_cgram_nx;
        r_disp_on  <= w_disp_nx;
        r_busy_cnt <= w_busy_ld;
        r_pend_clr <= w_clr_req;
        if (w_store) begin
          r_wr_strobe <= 1'b1;
          r_wr_pos    <= w_pos;
          r_wr_char   <= r_data_s2;
        end
      end else begin
        if (w_rd_step) r_ac <= f_ac_step(r_ac, r_id);
        if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - 1'b1;
        if (r_state == ST_EXEC) r_pend_clr <= 1'b0;
      end
      if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 5'd1;
      else                     r_clr_idx <= 5'd0;
    end
  end

  // Fill writes and char stores never coincide: captures during CLEAR are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= 8'h20;
      r_rd_char <= 8'h20;
    end else begin
      if (r_state == ST_CLEAR)     r_shadow[r_clr_idx] <= 8'h20;
      else if (w_exec && w_store)  r_shadow[w_pos]     <= r_data_s2;
      r_rd_char <= r_shadow[i_rd_addr];
    end
  end

  assign o_rd_char     = r_rd_char;
  assign o_ac          = r_ac;
  assign o_busy        = (r_busy_cnt != '0);
  assign o_disp_on     = r_disp_on;
  assign o_wr_strobe   = r_wr_strobe;
  assign o_wr_pos      = r_wr_pos;
  assign o_wr_char     = r_wr_char;
  assign o_clear_pulse = r_clear_pulse;
  assign o_err_busy    = r_err_busy;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: address/char vector table plus busy, fill, reset and read sequences.
module tb_lcd_bus_decoder;

  localparam int BS = 20;
  localparam int BL = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       busy, disp_on, wr_strobe, clear_pulse, err_busy;
  logic [4:0] wr_pos;
  logic [7:0] wr_char;
`ifdef LCD_MON_READ_EN
  logic [7:0] lcd_dq;
  logic       lcd_dq_oe;
`endif

  lcd_bus_decoder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .clk(clk), .rst(rst),
    .i_lcd_rs(lcd_rs), .i_lcd_rw(lcd_rw), .i_lcd_e(lcd_e), .i_lcd_data(lcd_data),
    .i_rd_addr(rd_addr), .o_rd_char(rd_char), .o_ac(ac), .o_busy(busy),
    .o_disp_on(disp_on), .o_wr_strobe(wr_strobe), .o_wr_pos(wr_pos),
    .o_wr_char(wr_char), .o_clear_pulse(clear_pulse), .o_err_busy(err_busy)
`ifdef LCD_MON_READ_EN
    , .o_lcd_dq(lcd_dq), .o_lcd_dq_oe(lcd_dq_oe)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] chr;
    logic       store;
    logic [4:0] pos;
    logic [6:0] ac;
  } vec_t;

  vec_t        vt[9];
  logic [12:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_cnt = 0;
  int          clr_pulses = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock of observation: sample on the falling edge, score any strobe.
  task automatic tick();
    logic [12:0] e;
    @(negedge clk);
    if (busy) busy_cnt++;
    if (clear_pulse) clr_pulses++;
    if (wr_strobe) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL strobe_unexpected: got pos %0d char %0h expected none", wr_pos, wr_char);
      end else begin
        e = exp_q.pop_front();
        check("strobe_pos_char", {19'd0, wr_pos, wr_char}, {19'd0, e});
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    ticks(4);
    lcd_e = 1'b0;
    ticks(6);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BL + 50) begin
      tick();
      n++;
    end
    if (busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    check($sformatf("rd_char[%0d]", a), {24'd0, rd_char}, {24'd0, exp});
  endtask

  initial begin
    int n;
    vt[0] = '{8'h80, 8'h41, 1'b1, 5'd0,  7'h01};
    vt[1] = '{8'h8F, 8'h42, 1'b1, 5'd15, 7'h10};
    vt[2] = '{8'hC0, 8'h43, 1'b1, 5'd16, 7'h41};
    vt[3] = '{8'hCF, 8'h44, 1'b1, 5'd31, 7'h50};
    vt[4] = '{8'h90, 8'h45, 1'b0, 5'd0,  7'h11};
    vt[5] = '{8'hA7, 8'h46, 1'b0, 5'd0,  7'h40};
    vt[6] = '{8'hE7, 8'h47, 1'b0, 5'd0,  7'h00};
    vt[7] = '{8'hB0, 8'h48, 1'b1, 5'd0,  7'h01};
    vt[8] = '{8'hF0, 8'h49, 1'b1, 5'd0,  7'h01};

    rst = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_data = 8'h00; rd_addr = 5'd0;
    ticks(3);
    check("reset_ac", {25'd0, ac}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_outputs", {27'd0, disp_on, wr_strobe, clear_pulse, err_busy, 1'b0}, 32'h0);
    check("reset_rd_char", {24'd0, rd_char}, 32'h20);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) rd_check(5'(a), 8'h20);

    // Address/char table.
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      xfer(1'b0, 1'b0, vt[i].cmd);
      wait_idle();
      if (vt[i].store) exp_q.push_back({vt[i].pos, vt[i].chr});
      xfer(1'b1, 1'b0, vt[i].chr);
      check($sformatf("vec%0d_ac", i), {25'd0, ac}, {25'd0, vt[i].ac});
      if (vt[i].store) rd_check(vt[i].pos, vt[i].chr);
    end
    check("vec_queue_empty", exp_q.size(), 32'd0);

    // Latency from raw E fall and exact busy length.
    wait_idle();
    xfer(1'b0, 1'b0, 8'h80);
    wait_idle();
    exp_q.push_back({5'd0, 8'h41});
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h41; lcd_e = 1'b1;
    ticks(4);
    lcd_e = 1'b0;
    busy_cnt = 0;
    ticks(2);
    check("busy_not_early", {31'd0, busy}, 32'd0);
    tick();
    check("busy_latency3", {31'd0, busy}, 32'd1);
    check("ac_after_write", {25'd0, ac}, 32'h01);
    wait_idle();
    check("busy_short_len", busy_cnt, BS);
    check("single_strobe", exp_q.size(), 32'd0);

    // Line 2 fill; 17th write lands past the visible cells.
    wait_idle();
    xfer(1'b0, 1'b0, 8'hC0);
    for (int i = 0; i < 17; i++) begin
      wait_idle();
      if (i < 16) exp_q.push_back({5'(16 + i), 8'(8'h60 + i)});
      xfer(1'b1, 1'b0, 8'(8'h60 + i));
    end
    check("line2_ac", {25'd0, ac}, 32'h51);
    check("line2_strobes", exp_q.size(), 32'd0);
    for (int i = 0; i < 16; i++) rd_check(5'(16 + i), 8'(8'h60 + i));

    // AC wrap in both directions.
    wait_idle(); xfer(1'b0, 1'b0, 8'hA7);
    wait_idle(); xfer(1'b1, 1'b0, 8'h70);
    check("wrap_27_40", {25'd0, ac}, 32'h40);
    wait_idle(); xfer(1'b0, 1'b0, 8'h04);
    wait_idle(); xfer(1'b0, 1'b0, 8'h80);
    wait_idle();
    exp_q.push_back({5'd0, 8'h71});
    xfer(1'b1, 1'b0, 8'h71);
    check("wrap_00_67", {25'd0, ac}, 32'h67);

    // Display control, cursor moves, CGRAM discard.
    wait_idle(); xfer(1'b0, 1'b0, 8'h0C);
    check("disp_on", {31'd0, disp_on}, 32'd1);
    wait_idle(); xfer(1'b0, 1'b0, 8'h14);
    check("cursor_inc_wrap", {25'd0, ac}, 32'h00);
    wait_idle(); xfer(1'b0, 1'b0, 8'h10);
    check("cursor_dec_wrap", {25'd0, ac}, 32'h67);
    wait_idle(); xfer(1'b0, 1'b0, 8'h18);
    check("display_shift_ignored", {25'd0, ac}, 32'h67);
    wait_idle(); xfer(1'b0, 1'b0, 8'h08);
    check("disp_off", {31'd0, disp_on}, 32'd0);
    wait_idle(); xfer(1'b0, 1'b0, 8'h06);
    wait_idle(); xfer(1'b0, 1'b0, 8'h40);
    wait_idle(); xfer(1'b1, 1'b0, 8'h72);
    check("cgram_ac_kept", {25'd0, ac}, 32'h67);
    wait_idle(); xfer(1'b0, 1'b0, 8'h80);
    wait_idle(); xfer(1'b0, 1'b0, 8'h38);
    check("funcset_ac", {25'd0, ac}, 32'h00);
    wait_idle(); xfer(1'b1, 1'b1, 8'h99);
`ifdef LCD_MON_READ_EN
    check("read_step_ac", {25'd0, ac}, 32'h01);
`else
    check("rw1_ignored_ac", {25'd0, ac}, 32'h00);
`endif
    check("no_err_yet", {31'd0, err_busy}, 32'd0);

    // Clear with a write dropped mid-fill.
    wait_idle();
    busy_cnt = 0;
    clr_pulses = 0;
    xfer(1'b0, 1'b0, 8'h01);
    xfer(1'b1, 1'b0, 8'h5A);
    n = 0;
    while (clr_pulses == 0 && n < 40) begin
      tick();
      n++;
    end
    check("clear_pulse_seen", clr_pulses, 32'd1);
    check("clear_ac", {25'd0, ac}, 32'h00);
    check("err_in_clear", {31'd0, err_busy}, 32'd1);
    check("busy_after_fill", {31'd0, busy}, 32'd1);
    wait_idle();
    check("busy_long_len", busy_cnt, BL);
    check("clear_pulse_once", clr_pulses, 32'd1);
    for (int a = 0; a < 32; a++) rd_check(5'(a), 8'h20);

    // Reset while busy, then a write while busy.
    xfer(1'b0, 1'b0, 8'h02);
    check("home_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err_busy}, 32'd0);
    rst = 1'b0;
    tick();
    xfer(1'b0, 1'b0, 8'h85);
    exp_q.push_back({5'd5, 8'h55});
    xfer(1'b1, 1'b0, 8'h55);
    check("busy_write_ac", {25'd0, ac}, 32'h06);
    check("busy_write_err", {31'd0, err_busy}, 32'd1);
    check("busy_write_reload", {31'd0, busy}, 32'd1);
    rd_check(5'd5, 8'h55);

`ifdef LCD_MON_READ_EN
    wait_idle();
    xfer(1'b0, 1'b0, 8'h85);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
    tick();
    check("oe_before_sync", {31'd0, lcd_dq_oe}, 32'd0);
    tick();
    check("oe_during_e", {31'd0, lcd_dq_oe}, 32'd1);
    check("dq_busy_ac", {24'd0, lcd_dq}, 32'h85);
    lcd_e = 1'b0;
    ticks(3);
    check("oe_after_e", {31'd0, lcd_dq_oe}, 32'd0);
    check("status_read_ac", {25'd0, ac}, 32'h05);
    lcd_rw = 1'b0;
`endif

    ticks(4);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
